// File: rtl/i2c_burst_master.sv
// Single-master I2C burst engine: START, 7-bit address + R/W, up to MAX_BYTES data bytes, STOP.
// Every START/bit/ACK/STOP slot lasts one SCL period of CLK_DIV clocks; all outputs are registered.
module i2c_burst_master #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_stb,
    input  logic                   rnw,
    input  logic [6:0]             i2c_addr,
    input  logic [3:0]             num_bytes,
    input  logic [8*MAX_BYTES-1:0] wr_data,
    input  logic                   sda_in,
    output logic                   scl,
    output logic                   sda_out,
    output logic                   sda_oe,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   nack_err,
    output logic [3:0]             state_dbg
);
    localparam int W  = 8 * MAX_BYTES;
    localparam int Q  = CLK_DIV / 4;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] C_Q1   = CW'(Q - 1);
    localparam logic [CW-1:0] C_2Q1  = CW'(2 * Q - 1);
    localparam logic [CW-1:0] C_3Q1  = CW'(3 * Q - 1);
    localparam logic [CW-1:0] C_3Q   = CW'(3 * Q);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
    localparam logic [3:0]    MAXB   = 4'(MAX_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [3:0]      byte_q, n_q, n_clamp;
    logic            rnw_q;
    logic [7:0]      addr_q;
    logic [W-1:0]    wr_q, rd_q;
    logic            nack_q, scl_q, sda_q, oe_q, busy_q, done_q;
    logic            last, last_byte, nack_hit, rel_d;

    assign last      = (cnt_q == C_LAST);
    assign last_byte = (byte_q == n_q - 4'd1);
    assign n_clamp   = (num_bytes > MAXB) ? MAXB : num_bytes;
    // With CLK_DIV=4 the ACK sample point is also the last cycle, so look at sda_in directly.
    assign nack_hit  = nack_q | ((cnt_q == C_3Q) & sda_in);
    assign rel_d     = (state_d == S_ADDR_ACK) || (state_d == S_WR_ACK) || (state_d == S_RD_BYTE);

    // Handshake: start_stb is a request strobe taken only in IDLE (busy low); there is no
    // ready, and strobes while busy are dropped. done marks completion for exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_stb) state_d = S_START;
            S_START:    if (last) state_d = S_ADDR;
            S_ADDR:     if (last && bit_q == 3'd7) state_d = S_ADDR_ACK;
            S_ADDR_ACK: if (last) begin
                            if (nack_hit || n_q == 4'd0) state_d = S_STOP;
                            else if (rnw_q)              state_d = S_RD_BYTE;
                            else                         state_d = S_WR_BYTE;
                        end
            S_WR_BYTE:  if (last && bit_q == 3'd7) state_d = S_WR_ACK;
            S_WR_ACK:   if (last) state_d = (nack_hit || last_byte) ? S_STOP : S_WR_BYTE;
            S_RD_BYTE:  if (last && bit_q == 3'd7) state_d = S_RD_ACK;
            S_RD_ACK:   if (last) state_d = last_byte ? S_STOP : S_RD_BYTE;
            S_STOP:     if (last) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            n_q     <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            nack_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_STOP) && (state_d == S_IDLE);
            if (state_q == S_IDLE) begin
                cnt_q <= '0;
                if (start_stb) begin
                    rnw_q  <= rnw;
                    addr_q <= {i2c_addr, rnw};
                    n_q    <= n_clamp;
                    // Left-align the payload so the first byte always sits at the top.
                    wr_q   <= wr_data << {MAXB - n_clamp, 3'b000};
                    rd_q   <= '0;
                    nack_q <= 1'b0;
                    bit_q  <= '0;
                    byte_q <= '0;
                end
            end else begin
                cnt_q <= last ? '0 : cnt_q + CW'(1);
                if (cnt_q == C_3Q) begin
                    if ((state_q == S_ADDR_ACK || state_q == S_WR_ACK) && sda_in) nack_q <= 1'b1;
                    if (state_q == S_RD_BYTE) rd_q <= {rd_q[W-2:0], sda_in};
                end
                if (cnt_q == C_2Q1 && state_q != S_START) scl_q <= 1'b1;
                if (cnt_q == C_Q1) begin
                    case (state_q)
                        S_ADDR:    sda_q <= addr_q[7];
                        S_WR_BYTE: sda_q <= wr_q[W-1];
                        S_RD_ACK:  sda_q <= last_byte;
                        default:   ;
                    endcase
                end
                if (state_q == S_START && cnt_q == C_2Q1) sda_q <= 1'b0;
                if (state_q == S_STOP && cnt_q == C_3Q1)  sda_q <= 1'b1;
                if (last) begin
                    case (state_q)
                        S_ADDR:    begin addr_q <= addr_q << 1; bit_q <= bit_q + 3'd1; end
                        S_WR_BYTE: begin wr_q <= wr_q << 1;     bit_q <= bit_q + 3'd1; end
                        S_RD_BYTE: bit_q  <= bit_q + 3'd1;
                        S_WR_ACK,
                        S_RD_ACK:  byte_q <= byte_q + 4'd1;
                        default:   ;
                    endcase
                    scl_q <= (state_d == S_IDLE);
                    oe_q  <= !rel_d;
                    if (rel_d)              sda_q <= 1'b1;
                    if (state_d == S_STOP)  sda_q <= 1'b0;
                end
            end
        end
    end

    assign scl       = scl_q;
    assign sda_out   = sda_q;
    assign sda_oe    = oe_q;
    assign rd_data   = rd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign nack_err  = nack_q;
    assign state_dbg = state_q;
endmodule
